idu_qstage: RTL and testbench
=============================

IDU_QSTAGE -- requirements
Module: idu_qstage

Interface
REQ-001 Parameter QDEPTH, default 4: instruction queue entries; SHALL be a power of two, >= 2.
REQ-002 Parameter EN_M, default 1: 1 decodes RV32M (MUL..REMU); 0 flags those encodings illegal.
REQ-003 Ports, in this order:
- i_clk  in  1  clock. One clock domain.
- i_rst  in  1  synchronous active-high reset.
- i_flush  in  1  discard queue and output register.
- i_valid  in  1  fetch offers i_in/i_pc.
- o_ready  out  1  queue can accept.
- i_in  in  32  instruction word.
- i_pc  in  32  its PC.
- o_valid  out  1  decoded bundle valid.
- i_ready  in  1  issue accepts bundle.
- o_usele  out  5  one-hot unit select {MDU,CSU,AGU,BJU,ALU}, bit0=ALU.
- o_fun3  out  3  i_in[14:12].
- o_alt  out  1  i_in[30] for R-type/shift-immediate, else 0.
- o_rs1_idx, o_rs2_idx, o_rd_idx  out  5 each  register indices.
- o_rs1_ren, o_rs2_ren, o_rd_wen  out  1 each  register-port enables.
- o_csr_idx  out  12  i_in[31:20].
- o_im  out  32  selected immediate.
- o_pc  out  32  PC of the bundle.
- o_ilgl  out  1  illegal instruction.
- o_cnt  out  $clog2(QDEPTH)+1  queue occupancy.
REQ-004 Reset is synchronous and active-high on i_rst; single clock i_clk.

Function
REQ-005 Push: i_valid & o_ready & ~i_flush at a rising edge writes {i_in,i_pc} at the write pointer. o_ready = (o_cnt != QDEPTH). No bypass.
REQ-006 Pointers SHALL wrap modulo QDEPTH. o_cnt increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
REQ-007 The head entry SHALL be decoded combinationally. Output register load enable = head present & (~o_valid | i_ready). Load pops the head.
REQ-008 Latency: an instruction pushed at edge N SHALL present o_valid=1 at the earliest after edge N+1. Sustained throughput SHALL be 1 per cycle when i_ready=1.
REQ-009 While o_valid=1 & i_ready=0, all output fields SHALL hold stable.
REQ-010 o_valid SHALL clear after an edge with i_ready=1 when no new load occurs.
REQ-011 NOP drop: OP, OP-IMM, LUI or AUIPC with rd=x0 that is legal SHALL be popped without loading the output register. It consumes the same pop slot and produces no bundle.
REQ-012 Unit select:
- ALU: OP (non-M), OP-IMM, LUI.
- BJU: BRANCH, JAL, JALR, AUIPC, MRET.
- AGU: LOAD, STORE.
- CSU: CSRR* with fun3 != 000.
- MDU: OP with fun7=0000001 and EN_M=1.
REQ-013 Immediate selection:
- OP-IMM, LOAD, JALR: I-imm.
- STORE: S-imm.
- BRANCH: B-imm.
- LUI, AUIPC: U-imm.
- JAL: J-imm.
- CSR: zero-extended i_in[19:15].
- Otherwise 0.
REQ-014 Register-port enables:
- rs1_ren: OP, OP-IMM, LOAD, STORE, BRANCH, JALR, register-form CSR.
- rs2_ren: OP, STORE, BRANCH.
- rd_wen: OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC, CSR, with rd != x0.
- o_rs1_idx SHALL be 0 for LUI.
REQ-015 o_ilgl=1 conditions:
- Unknown opcode.
- OP fun7 not in {0000000, 0100000 (fun3 000/101 only), 0000001 with EN_M=1}.
- LOAD fun3 in {011, 110, 111}.
- STORE fun3 > 010.
- BRANCH fun3 in {010, 011}.
- JALR fun3 != 000.
- SYSTEM fun3=000 with imm not ECALL/EBREAK/MRET.
- Shift-immediate with i_in[31:26] illegal or i_in[25]=1.
- All-zero or all-one word.
REQ-016 An illegal instruction SHALL be delivered with o_ilgl=1, o_usele=0, and all enables 0. It SHALL NOT be dropped.
REQ-017 i_flush=1 SHALL, at the next edge, empty the queue (pointers 0, o_cnt=0), clear o_valid, and ignore any simultaneous push. i_flush has priority over push, pop and load.

Reset
REQ-018 On i_rst=1 at an edge: queue pointers 0, o_cnt=0, o_valid=0. All bundle outputs SHALL be 0. o_ready SHALL be 1 in the cycle after reset.
REQ-019 Reset mid-operation SHALL discard all queued and presented instructions. No bundle SHALL appear until a new push.
REQ-020 Queue storage SHALL NOT require reset.

Verification
REQ-021 Push 0x003100B3 (add x1,x2,x3), PC 0x100, i_ready=1 -> bundle next cycle after decode with:
- o_usele=00001, rd=1, rs1=2, rs2=3, fun3=0, o_rd_wen=1, o_pc=0x100.
REQ-022 Push 0x00000013 then 0x003100B3 -> exactly one bundle, the add; o_cnt returns to 0.
REQ-023 Push 0x027302B3 -> EN_M=1: o_usele=10000, rd=5. EN_M=0: o_ilgl=1, o_usele=0.
REQ-024 Push 0x02009093 (slli, bit25=1) -> o_ilgl=1, o_rd_wen=0.
REQ-025 QDEPTH=4, i_ready=0, push 6 legal instructions -> o_cnt reaches 4 with o_ready=0, one bundle held stable. Release i_ready -> all 5 delivered in order, one per cycle.
REQ-026 Queue holding 3, o_valid=1, assert i_flush together with i_valid -> next cycle o_cnt=0, o_valid=0, and the flushed-cycle input is never delivered.

Source files
------------

// File: rtl/idu_qstage.sv
// Instruction queue plus RV32I(M) decode stage. Fetch pushes {word,pc} into a small FIFO;
// the head is decoded combinationally and captured into a registered issue bundle.
module idu_qstage #(
  parameter int QDEPTH = 4,
  parameter int EN_M   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [31:0]             i_in,
  input  logic [31:0]             i_pc,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [4:0]              o_usele,
  output logic [2:0]              o_fun3,
  output logic                    o_alt,
  output logic [4:0]              o_rs1_idx,
  output logic [4:0]              o_rs2_idx,
  output logic [4:0]              o_rd_idx,
  output logic                    o_rs1_ren,
  output logic                    o_rs2_ren,
  output logic                    o_rd_wen,
  output logic [11:0]             o_csr_idx,
  output logic [31:0]             o_im,
  output logic [31:0]             o_pc,
  output logic                    o_ilgl,
  output logic [$clog2(QDEPTH):0] o_cnt
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [4:0] U_ALU = 5'b00001;
  localparam logic [4:0] U_BJU = 5'b00010;
  localparam logic [4:0] U_AGU = 5'b00100;
  localparam logic [4:0] U_CSU = 5'b01000;
  localparam logic [4:0] U_MDU = 5'b10000;

  logic [63:0]   mem_q [QDEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;

  logic [4:0]  usele_q, rs1_q, rs2_q, rd_q;
  logic [2:0]  fun3_q;
  logic        alt_q, rs1r_q, rs2r_q, rdw_q, ilgl_q;
  logic [11:0] csr_q;
  logic [31:0] im_q, pc_q;

  logic [63:0] head_s;
  logic [31:0] hw_s;
  logic [6:0]  op_s, f7_s;
  logic [2:0]  f3_s;
  logic [4:0]  rd_s;
  logic [4:0]  raw_usele_s;
  logic        raw_rs1r_s, raw_rs2r_s, raw_rdw_s, raw_ilgl_s, alt_s, nopc_s;
  logic [31:0] imm_s;
  logic        ilgl_s, drop_s, have_s, push_s, pop_s, load_s;

  assign head_s = mem_q[rptr_q];
  assign hw_s   = head_s[63:32];
  assign op_s   = hw_s[6:0];
  assign f3_s   = hw_s[14:12];
  assign f7_s   = hw_s[31:25];
  assign rd_s   = hw_s[11:7];

  // Raw decode of the head word; illegal masking is applied afterwards.
  always_comb begin
    raw_usele_s = 5'b00000;
    raw_rs1r_s  = 1'b0;
    raw_rs2r_s  = 1'b0;
    raw_rdw_s   = 1'b0;
    raw_ilgl_s  = 1'b0;
    alt_s       = 1'b0;
    imm_s       = 32'h0000_0000;
    case (op_s)
      OP_OP: begin
        raw_rs1r_s = 1'b1; raw_rs2r_s = 1'b1; raw_rdw_s = 1'b1; alt_s = hw_s[30];
        case (f7_s)
          7'b0000000: raw_usele_s = U_ALU;
          7'b0100000: begin
            raw_usele_s = U_ALU;
            raw_ilgl_s  = (f3_s != 3'b000) && (f3_s != 3'b101);
          end
          7'b0000001: begin
            raw_usele_s = (EN_M != 0) ? U_MDU : 5'b00000;
            raw_ilgl_s  = (EN_M == 0);
          end
          default: raw_ilgl_s = 1'b1;
        endcase
      end
      OP_IMM: begin
        raw_usele_s = U_ALU; raw_rs1r_s = 1'b1; raw_rdw_s = 1'b1;
        imm_s = {{20{hw_s[31]}}, hw_s[31:20]};
        case (f3_s)
          3'b001: begin
            alt_s      = hw_s[30];
            raw_ilgl_s = (hw_s[31:26] != 6'b000000) || hw_s[25];
          end
          3'b101: begin
            alt_s      = hw_s[30];
            raw_ilgl_s = ((hw_s[31:26] != 6'b000000) && (hw_s[31:26] != 6'b010000)) || hw_s[25];
          end
          default: alt_s = 1'b0;
        endcase
      end
      OP_LUI:   begin raw_usele_s = U_ALU; raw_rdw_s = 1'b1; imm_s = {hw_s[31:12], 12'h000}; end
      OP_AUIPC: begin raw_usele_s = U_BJU; raw_rdw_s = 1'b1; imm_s = {hw_s[31:12], 12'h000}; end
      OP_JAL: begin
        raw_usele_s = U_BJU; raw_rdw_s = 1'b1;
        imm_s = {{11{hw_s[31]}}, hw_s[31], hw_s[19:12], hw_s[20], hw_s[30:21], 1'b0};
      end
      OP_JALR: begin
        raw_usele_s = U_BJU; raw_rs1r_s = 1'b1; raw_rdw_s = 1'b1;
        imm_s = {{20{hw_s[31]}}, hw_s[31:20]};
        raw_ilgl_s = (f3_s != 3'b000);
      end
      OP_BR: begin
        raw_usele_s = U_BJU; raw_rs1r_s = 1'b1; raw_rs2r_s = 1'b1;
        imm_s = {{19{hw_s[31]}}, hw_s[31], hw_s[7], hw_s[30:25], hw_s[11:8], 1'b0};
        raw_ilgl_s = (f3_s == 3'b010) || (f3_s == 3'b011);
      end
      OP_LOAD: begin
        raw_usele_s = U_AGU; raw_rs1r_s = 1'b1; raw_rdw_s = 1'b1;
        imm_s = {{20{hw_s[31]}}, hw_s[31:20]};
        raw_ilgl_s = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
      end
      OP_STORE: begin
        raw_usele_s = U_AGU; raw_rs1r_s = 1'b1; raw_rs2r_s = 1'b1;
        imm_s = {{20{hw_s[31]}}, hw_s[31:25], hw_s[11:7]};
        raw_ilgl_s = (f3_s > 3'b010);
      end
      OP_SYS: begin
        if (f3_s == 3'b000) begin
          case (hw_s[31:20])
            12'h000, 12'h001: raw_usele_s = 5'b00000;
            12'h302:          raw_usele_s = U_BJU;
            default:          raw_ilgl_s  = 1'b1;
          endcase
        end else begin
          raw_usele_s = U_CSU; raw_rdw_s = 1'b1; raw_rs1r_s = ~f3_s[2];
          imm_s = {27'h000_0000, hw_s[19:15]};
        end
      end
      default: raw_ilgl_s = 1'b1;
    endcase
  end

  assign ilgl_s = raw_ilgl_s || (hw_s == 32'h0000_0000) || (hw_s == 32'hFFFF_FFFF);
  assign nopc_s = (op_s == OP_OP) || (op_s == OP_IMM) || (op_s == OP_LUI) || (op_s == OP_AUIPC);
  assign drop_s = nopc_s && (rd_s == 5'd0) && !ilgl_s;

  assign have_s = (cnt_q != {CW{1'b0}});
  assign push_s = i_valid && o_ready && !i_flush;
  assign pop_s  = have_s && (!vld_q || i_ready) && !i_flush;
  assign load_s = pop_s && !drop_s;

  // Queue pointer, occupancy and bundle-valid next state; flush clears everything.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    if (i_flush) begin
      wptr_d = {AW{1'b0}};
      rptr_d = {AW{1'b0}};
      cnt_d  = {CW{1'b0}};
      vld_d  = 1'b0;
    end else begin
      wptr_d = push_s ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop_s ? rptr_q + 1'b1 : rptr_q;
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (load_s) begin
        vld_d = 1'b1;
      end else if (i_ready) begin
        vld_d = 1'b0;
      end else begin
        vld_d = vld_q;
      end
    end
  end

  // Control state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= {AW{1'b0}};
      rptr_q <= {AW{1'b0}};
      cnt_q  <= {CW{1'b0}};
      vld_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  // Queue storage, write-only on push.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= {i_in, i_pc};
    end
  end

  // Issue bundle register; illegal words go out with unit select and enables cleared.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      usele_q <= 5'b00000; fun3_q <= 3'b000; alt_q <= 1'b0;
      rs1_q <= 5'd0; rs2_q <= 5'd0; rd_q <= 5'd0;
      rs1r_q <= 1'b0; rs2r_q <= 1'b0; rdw_q <= 1'b0;
      csr_q <= 12'h000; im_q <= 32'h0000_0000; pc_q <= 32'h0000_0000; ilgl_q <= 1'b0;
    end else if (load_s) begin
      usele_q <= ilgl_s ? 5'b00000 : raw_usele_s;
      fun3_q  <= f3_s;
      alt_q   <= alt_s;
      rs1_q   <= (op_s == OP_LUI) ? 5'd0 : hw_s[19:15];
      rs2_q   <= hw_s[24:20];
      rd_q    <= rd_s;
      rs1r_q  <= raw_rs1r_s && !ilgl_s;
      rs2r_q  <= raw_rs2r_s && !ilgl_s;
      rdw_q   <= raw_rdw_s && !ilgl_s && (rd_s != 5'd0);
      csr_q   <= hw_s[31:20];
      im_q    <= imm_s;
      pc_q    <= head_s[31:0];
      ilgl_q  <= ilgl_s;
    end
  end

  assign o_ready   = (cnt_q != FULL);
  assign o_cnt     = cnt_q;
  assign o_valid   = vld_q;
  assign o_usele   = usele_q;
  assign o_fun3    = fun3_q;
  assign o_alt     = alt_q;
  assign o_rs1_idx = rs1_q;
  assign o_rs2_idx = rs2_q;
  assign o_rd_idx  = rd_q;
  assign o_rs1_ren = rs1r_q;
  assign o_rs2_ren = rs2r_q;
  assign o_rd_wen  = rdw_q;
  assign o_csr_idx = csr_q;
  assign o_im      = im_q;
  assign o_pc      = pc_q;
  assign o_ilgl    = ilgl_q;
endmodule

// File: tb/tb_idu_qstage.sv
// Directed bench for idu_qstage: decode vectors, NOP drop, backpressure, flush and reset.
module tb_idu_qstage;
  logic        clk, rst, flush, valid, ready;
  logic [31:0] in_w, pc_w;

  logic        rdy_a, vld_a, alt_a, r1e_a, r2e_a, wen_a, il_a;
  logic [4:0]  us_a, r1_a, r2_a, rd_a;
  logic [2:0]  f3_a;
  logic [11:0] csr_a;
  logic [31:0] im_a, pco_a;
  logic [2:0]  cnt_a;

  logic        rdy_b, vld_b, alt_b, r1e_b, r2e_b, wen_b, il_b;
  logic [4:0]  us_b, r1_b, r2_b, rd_b;
  logic [2:0]  f3_b;
  logic [11:0] csr_b;
  logic [31:0] im_b, pco_b;
  logic [2:0]  cnt_b;

  int n_vec = 0;
  int n_err = 0;

  idu_qstage #(.QDEPTH(4), .EN_M(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy_a),
    .i_in(in_w), .i_pc(pc_w), .o_valid(vld_a), .i_ready(ready), .o_usele(us_a),
    .o_fun3(f3_a), .o_alt(alt_a), .o_rs1_idx(r1_a), .o_rs2_idx(r2_a), .o_rd_idx(rd_a),
    .o_rs1_ren(r1e_a), .o_rs2_ren(r2e_a), .o_rd_wen(wen_a), .o_csr_idx(csr_a),
    .o_im(im_a), .o_pc(pco_a), .o_ilgl(il_a), .o_cnt(cnt_a));

  idu_qstage #(.QDEPTH(4), .EN_M(0)) dut_nom (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy_b),
    .i_in(in_w), .i_pc(pc_w), .o_valid(vld_b), .i_ready(ready), .o_usele(us_b),
    .o_fun3(f3_b), .o_alt(alt_b), .o_rs1_idx(r1_b), .o_rs2_idx(r2_b), .o_rd_idx(rd_b),
    .o_rs1_ren(r1e_b), .o_rs2_ren(r2e_b), .o_rd_wen(wen_b), .o_csr_idx(csr_b),
    .o_im(im_b), .o_pc(pco_b), .o_ilgl(il_b), .o_cnt(cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One push, then one more edge so a legal, non-dropped word is presented.
  task automatic push1(input logic [31:0] w, input logic [31:0] p);
    valid = 1'b1; in_w = w; pc_w = p;
    step();
    valid = 1'b0;
    step();
  endtask

  typedef struct packed {
    logic [31:0] w;
    logic [4:0]  u;
    logic        il;
    logic [31:0] im;
    logic        rw;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];
  int   seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'hFFC12283, 5'b00100, 1'b0, 32'hFFFF_FFFC, 1'b1}; // lw x5,-4(x2)
    tbl[1]  = '{32'h00312423, 5'b00100, 1'b0, 32'h0000_0008, 1'b0}; // sw x3,8(x2)
    tbl[2]  = '{32'hFE208CE3, 5'b00010, 1'b0, 32'hFFFF_FFF8, 1'b0}; // beq x1,x2,-8
    tbl[3]  = '{32'h123453B7, 5'b00001, 1'b0, 32'h1234_5000, 1'b1}; // lui x7
    tbl[4]  = '{32'h010000EF, 5'b00010, 1'b0, 32'h0000_0010, 1'b1}; // jal x1,16
    tbl[5]  = '{32'h3052D1F3, 5'b01000, 1'b0, 32'h0000_0005, 1'b1}; // csrrwi x3,0x305,5
    tbl[6]  = '{32'h40315093, 5'b00001, 1'b0, 32'h0000_0403, 1'b1}; // srai x1,x2,3
    tbl[7]  = '{32'h000090E7, 5'b00000, 1'b1, 32'h0000_0000, 1'b0}; // jalr fun3=001
    tbl[8]  = '{32'h00000073, 5'b00000, 1'b0, 32'h0000_0000, 1'b0}; // ecall
    tbl[9]  = '{32'h30200073, 5'b00010, 1'b0, 32'h0000_0000, 1'b0}; // mret
    tbl[10] = '{32'hFFFFFFFF, 5'b00000, 1'b1, 32'h0000_0000, 1'b0}; // all ones
    tbl[11] = '{32'h403110B3, 5'b00000, 1'b1, 32'h0000_0000, 1'b0}; // fun7=0100000 fun3=001
    tbl[12] = '{32'h00016283, 5'b00000, 1'b1, 32'h0000_0000, 1'b0}; // load fun3=110

    rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b1; in_w = 32'h0; pc_w = 32'h0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", vld_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_ready", rdy_a, 1);
    chk("rst_usele", us_a, 0);
    chk("rst_im", im_a, 0);
    chk("rst_pc", pco_a, 0);

    // add x1,x2,x3 with latency check
    valid = 1'b1; in_w = 32'h003100B3; pc_w = 32'h100;
    step();
    valid = 1'b0;
    chk("add_lat_valid", vld_a, 0);
    chk("add_lat_cnt", cnt_a, 1);
    step();
    chk("add_valid", vld_a, 1);
    chk("add_usele", us_a, 5'b00001);
    chk("add_rd", rd_a, 1);
    chk("add_rs1", r1_a, 2);
    chk("add_rs2", r2_a, 3);
    chk("add_fun3", f3_a, 0);
    chk("add_wen", wen_a, 1);
    chk("add_ren", {r1e_a, r2e_a}, 2'b11);
    chk("add_pc", pco_a, 32'h100);
    chk("add_ilgl", il_a, 0);
    step();
    chk("add_clear", vld_a, 0);

    // NOP drop: addi x0,x0,0 then add
    valid = 1'b1; in_w = 32'h00000013; pc_w = 32'h200;
    step();
    in_w = 32'h003100B3; pc_w = 32'h204;
    step();
    valid = 1'b0;
    chk("nop_no_bundle", vld_a, 0);
    step();
    chk("nop_add_valid", vld_a, 1);
    chk("nop_add_pc", pco_a, 32'h204);
    chk("nop_cnt0", cnt_a, 0);
    step();
    chk("nop_after", vld_a, 0);

    // mul x5,x6,x7 with and without M
    push1(32'h027302B3, 32'h300);
    chk("mul_usele", us_a, 5'b10000);
    chk("mul_rd", rd_a, 5);
    chk("mul_ilgl", il_a, 0);
    chk("mulx_valid", vld_b, 1);
    chk("mulx_ilgl", il_b, 1);
    chk("mulx_usele", us_b, 0);
    chk("mulx_wen", wen_b, 0);
    step();

    // slli with bit25 set
    push1(32'h02009093, 32'h304);
    chk("slli25_valid", vld_a, 1);
    chk("slli25_ilgl", il_a, 1);
    chk("slli25_wen", wen_a, 0);
    chk("slli25_usele", us_a, 0);
    step();

    for (int i = 0; i < NV; i++) begin
      push1(tbl[i].w, 32'h400 + 32'(4 * i));
      chk($sformatf("tv%0d_valid", i), vld_a, 1);
      chk($sformatf("tv%0d_usele", i), us_a, tbl[i].u);
      chk($sformatf("tv%0d_ilgl", i), il_a, tbl[i].il);
      chk($sformatf("tv%0d_im", i), im_a, tbl[i].im);
      chk($sformatf("tv%0d_wen", i), wen_a, tbl[i].rw);
      chk($sformatf("tv%0d_pc", i), pco_a, 32'h400 + 32'(4 * i));
      if (i == 3) chk("lui_rs1_zero", r1_a, 0);
      if (i == 5) chk("csr_idx", csr_a, 12'h305);
      if (i == 6) chk("srai_alt", alt_a, 1);
      step();
    end

    // Backpressure: 6 offered, 5 accepted
    ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      valid = 1'b1; in_w = 32'h003100B3; pc_w = 32'h800 + 32'(4 * k);
      step();
    end
    valid = 1'b0;
    chk("bp_cnt", cnt_a, 4);
    chk("bp_ready", rdy_a, 0);
    chk("bp_valid", vld_a, 1);
    chk("bp_pc", pco_a, 32'h800);
    step(); step();
    chk("bp_hold_pc", pco_a, 32'h800);
    chk("bp_hold_valid", vld_a, 1);
    ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp_out%0d_valid", j), vld_a, 1);
      chk($sformatf("bp_out%0d_pc", j), pco_a, 32'h800 + 32'(4 * j));
      step();
    end
    chk("bp_drain_valid", vld_a, 0);
    chk("bp_drain_cnt", cnt_a, 0);

    // Flush with simultaneous push
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1; in_w = 32'h003100B3; pc_w = 32'h900 + 32'(4 * k);
      step();
    end
    chk("fl_pre_cnt", cnt_a, 3);
    chk("fl_pre_valid", vld_a, 1);
    flush = 1'b1; valid = 1'b1; in_w = 32'h00500293; pc_w = 32'hA00;
    step();
    flush = 1'b0; valid = 1'b0;
    chk("fl_cnt", cnt_a, 0);
    chk("fl_valid", vld_a, 0);
    chk("fl_ready", rdy_a, 1);
    ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (vld_a) seen++;
    end
    chk("fl_no_bundle", seen, 0);

    // Reset mid-operation
    ready = 1'b0;
    valid = 1'b1; in_w = 32'h003100B3; pc_w = 32'hB00;
    step();
    pc_w = 32'hB04;
    step();
    valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_valid", vld_a, 0);
    chk("mr_cnt", cnt_a, 0);
    chk("mr_ready", rdy_a, 1);
    chk("mr_pc", pco_a, 0);
    chk("mr_usele", us_a, 0);
    ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (vld_a) seen++;
    end
    chk("mr_no_bundle", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
